// File: rtl/fetch_pc_if.sv
// Fetch unit bundle: execute-stage redirect, instruction-memory request/response
// and the decode-side handshake. master = fetch unit, slave = its environment.
interface fetch_pc_if;
  logic        branchTaken;
  logic [31:0] targetADDR;
  logic        missaligned_exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    input  branchTaken, targetADDR, missaligned_exception,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output branchTaken, targetADDR, missaligned_exception,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: sequential PC generation, single-outstanding imem request FSM,
// redirect/trap handling with stale-response discard, and a small {pc,instr}
// FIFO towards decode. Define FETCH_BUF2_EN for a 2-entry FIFO (default 1 entry).
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input logic        clk,
  input logic        rst_n,
  fetch_pc_if.master fif
);
`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C  = 2'(DEPTH);
  localparam logic       PTR_LAST = 1'(DEPTH - 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t      state, state_nxt;
  logic [31:0] fpc, req_pc, redir_pc;
  entry_t      fifo_q [DEPTH];
  entry_t      head;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        redirect, grant, push, pop, has_room;

  assign redirect = fif.missaligned_exception | fif.branchTaken;
  assign redir_pc = fif.missaligned_exception ? TRAP_VEC : {fif.targetADDR[31:2], 2'b00};

  // In REQ nothing is outstanding, so room means a free entry now or one freed by this pop.
  assign pop      = fif.if_valid & fif.if_ready;
  assign has_room = (count < DEPTH_C) | pop;
  assign fif.imem_req  = rst_n & (state == S_REQ) & has_room;
  assign fif.imem_addr = fpc;
  assign grant    = fif.imem_req & fif.imem_gnt;
  assign push     = (state == S_WAIT) & fif.imem_rvalid & ~redirect;

  assign head         = fifo_q[rd_ptr];
  assign fif.if_valid = (count != 2'd0);
  assign fif.if_pc    = fif.if_valid ? head.pc    : 32'h0;
  assign fif.if_instr = fif.if_valid ? head.instr : 32'h0;

  // Next state: a redirect while a response is in flight means that response must be dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:     if (grant) state_nxt = redirect ? S_DISCARD : S_WAIT;
      S_WAIT: begin
        if (fif.imem_rvalid)  state_nxt = S_REQ;
        else if (redirect)    state_nxt = S_DISCARD;
      end
      S_DISCARD: if (fif.imem_rvalid) state_nxt = S_REQ;
      default:   state_nxt = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  // Fetch PC: redirect wins over sequential advance; req_pc tags the in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      req_pc <= 32'h0;
    end else begin
      if (redirect)   fpc <= redir_pc;
      else if (grant) fpc <= fpc + 32'd4;
      if (grant) req_pc <= fpc;
    end
  end

  // FIFO pointers/occupancy; a redirect flushes everything that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? 1'b0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? 1'b0 : rd_ptr + 1'b1;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // FIFO storage; contents are only visible while non-empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: req_pc, instr: fif.imem_rdata};
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized memory/decode
// environment checked against a transaction-level model of the fetch stream.
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0010;
`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_if fif();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .fif(fif)
  );

  int checks = 0;
  int failures = 0;

  // model state: expected next fetch address, expected next delivered pc
  logic [31:0] exp_faddr, exp_dpc, pend_addr, prev_addr;
  logic        pend, prev_hold, prev_redir;
  int          pend_dly, pops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle();
    fif.branchTaken = 1'b0;
    fif.missaligned_exception = 1'b0;
    fif.targetADDR = 32'h0;
    fif.imem_gnt = 1'b0;
    fif.imem_rvalid = 1'b0;
    fif.imem_rdata = 32'h0;
    fif.if_ready = 1'b0;
  endtask

  // Ends at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(fif.imem_req), 32'h0);
    chk("rst_valid", 32'(fif.if_valid), 32'h0);
    chk("rst_if_pc", fif.if_pc, 32'h0);
    chk("rst_if_instr", fif.if_instr, 32'h0);
    chk("rst_addr", fif.imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    pend = 1'b0; pend_dly = 0; prev_hold = 1'b0; prev_redir = 1'b0;
    exp_faddr = RESET_PC; exp_dpc = RESET_PC;
  endtask

  // One cycle of the memory responder + model; caller sets redirect/if_ready first.
  task automatic cyc(input int gnt_pct, input int lat_max);
    logic redir, grant, popv;
    logic [31:0] tgt;
    fif.imem_rvalid = pend && (pend_dly == 0);
    fif.imem_rdata = fif.imem_rvalid ? word(pend_addr) : $urandom;
    #1;
    fif.imem_gnt = fif.imem_req && ($urandom_range(99) < gnt_pct);
    #1;
    redir = fif.branchTaken | fif.missaligned_exception;
    tgt   = fif.missaligned_exception ? TRAP_VEC : {fif.targetADDR[31:2], 2'b00};
    grant = fif.imem_req & fif.imem_gnt;
    popv  = fif.if_valid & fif.if_ready & ~redir;
    chk("one_outstanding", 32'(fif.imem_req & pend), 32'h0);
    if (prev_hold)  chk("addr_hold", fif.imem_addr, prev_addr);
    if (prev_redir) chk("flush_valid", 32'(fif.if_valid), 32'h0);
    if (grant)      chk("fetch_addr", fif.imem_addr, exp_faddr);
    if (popv) begin
      chk("deliver_pc", fif.if_pc, exp_dpc);
      chk("deliver_instr", fif.if_instr, word(fif.if_pc));
      exp_dpc = exp_dpc + 32'd4;
      pops++;
    end
    prev_hold  = fif.imem_req & ~fif.imem_gnt & ~redir;
    prev_addr  = fif.imem_addr;
    prev_redir = redir;
    if (redir) begin
      exp_faddr = tgt;
      exp_dpc   = tgt;
    end else if (grant) begin
      exp_faddr = exp_faddr + 32'd4;
    end
    if (fif.imem_rvalid) pend = 1'b0;
    else if (pend && pend_dly > 0) pend_dly--;
    if (grant) begin
      pend = 1'b1;
      pend_addr = fif.imem_addr;
      pend_dly = $urandom_range(lat_max);
    end
    @(negedge clk);
    fif.imem_gnt = 1'b0;
  endtask

  initial begin
    int base;
    idle();
    pops = 0;

    // first fetch after reset release, single word round trip
    do_reset();
    fif.if_ready = 1'b1;
    #1;
    chk("t35_req", 32'(fif.imem_req), 32'h1);
    chk("t35_addr", fif.imem_addr, 32'h0);
    fif.imem_gnt = 1'b1;
    @(negedge clk);
    fif.imem_gnt = 1'b0; fif.imem_rvalid = 1'b1; fif.imem_rdata = 32'h0000_0013;
    #1;
    chk("t35_wait_req", 32'(fif.imem_req), 32'h0);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    #1;
    chk("t35_valid", 32'(fif.if_valid), 32'h1);
    chk("t35_if_pc", fif.if_pc, 32'h0);
    chk("t35_if_instr", fif.if_instr, 32'h0000_0013);
    chk("t35_next_addr", fif.imem_addr, 32'h4);
    chk("t35_next_req", 32'(fif.imem_req), 32'h1);

    // branch while waiting: stale response dropped, refetch from target
    do_reset();
    fif.if_ready = 1'b1;
    #1;
    fif.imem_gnt = 1'b1;
    @(negedge clk);
    fif.imem_gnt = 1'b0; fif.branchTaken = 1'b1; fif.targetADDR = 32'h100;
    #1;
    chk("t36_wait_req", 32'(fif.imem_req), 32'h0);
    @(negedge clk);
    fif.branchTaken = 1'b0; fif.imem_rvalid = 1'b1; fif.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t36_discard_req", 32'(fif.imem_req), 32'h0);
    chk("t36_discard_valid", 32'(fif.if_valid), 32'h0);
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    #1;
    chk("t36_after_valid", 32'(fif.if_valid), 32'h0);
    chk("t36_after_req", 32'(fif.imem_req), 32'h1);
    chk("t36_after_addr", fif.imem_addr, 32'h100);
    fif.imem_gnt = 1'b1;
    @(negedge clk);
    fif.imem_gnt = 1'b0; fif.imem_rvalid = 1'b1; fif.imem_rdata = 32'h0000_0055;
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    #1;
    chk("t36_new_pc", fif.if_pc, 32'h100);
    chk("t36_new_instr", fif.if_instr, 32'h0000_0055);

    // trap has priority over branch
    do_reset();
    fif.missaligned_exception = 1'b1; fif.branchTaken = 1'b1; fif.targetADDR = 32'h200;
    @(negedge clk);
    idle();
    #1;
    chk("t37_addr", fif.imem_addr, TRAP_VEC);
    chk("t37_req", 32'(fif.imem_req), 32'h1);

    // PC wrap at top of address space
    do_reset();
    fif.branchTaken = 1'b1; fif.targetADDR = 32'hFFFF_FFFE;
    @(negedge clk);
    fif.branchTaken = 1'b0; fif.targetADDR = 32'h0;
    #1;
    chk("t39_addr_top", fif.imem_addr, 32'hFFFF_FFFC);
    fif.imem_gnt = 1'b1;
    @(negedge clk);
    fif.imem_gnt = 1'b0; fif.imem_rvalid = 1'b1; fif.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    #1;
    chk("t39_addr_wrap", fif.imem_addr, 32'h0);
    chk("t39_if_pc", fif.if_pc, 32'hFFFF_FFFC);

    // reset while waiting, late response after release is ignored
    do_reset();
    #1;
    fif.imem_gnt = 1'b1;
    @(negedge clk);
    fif.imem_gnt = 1'b0;
    #1;
    chk("t40_wait_req", 32'(fif.imem_req), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t40_rst_req", 32'(fif.imem_req), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    fif.imem_rvalid = 1'b1; fif.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    fif.imem_rvalid = 1'b0;
    #1;
    chk("t40_valid", 32'(fif.if_valid), 32'h0);
    chk("t40_addr", fif.imem_addr, RESET_PC);
    chk("t40_req", 32'(fif.imem_req), 32'h1);

    // decode stall with an eager memory: buffer fills to its depth, nothing lost
    do_reset();
    fif.if_ready = 1'b0;
    repeat (6) cyc(100, 0);
    #1;
    chk("t38_full_req", 32'(fif.imem_req), 32'h0);
    chk("t38_no_pend", 32'(pend), 32'h0);
    base = pops;
    fif.if_ready = 1'b1;
    repeat (4) cyc(0, 0);
    chk("t38_words", 32'(pops - base), 32'(DEPTH));

    // randomized traffic with redirects, traps and stalls
    do_reset();
    base = pops;
    for (int blk = 0; blk < 3; blk++) begin
      for (int n = 0; n < 1000; n++) begin
        fif.if_ready = ($urandom_range(99) < 70);
        fif.branchTaken = 1'b0;
        fif.missaligned_exception = 1'b0;
        if ($urandom_range(99) < 5) begin
          fif.branchTaken = 1'b1;
          fif.missaligned_exception = ($urandom_range(3) == 0);
          fif.targetADDR = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                    : $urandom;
        end
        cyc(blk == 0 ? 100 : (blk == 1 ? 50 : 80), blk == 0 ? 0 : (blk == 1 ? 3 : 1));
      end
    end
    chk("rand_progress", 32'(pops - base > 100), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0010, meaning redirect target on misaligned-target exception.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 branchTaken  in  1  execute-stage redirect request.
REQ-006 targetADDR  in  32  redirect target, valid when branchTaken=1.
REQ-007 missaligned_exception  in  1  execute-stage misaligned-target trap.
REQ-008 imem_req  out  1  instruction-memory request valid.
REQ-009 imem_addr  out  32  request word address.
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  response data valid.
REQ-012 imem_rdata  in  32  response instruction word.
REQ-013 if_valid  out  1  instruction available to decode.
REQ-014 if_instr  out  32  instruction word.
REQ-015 if_pc  out  32  PC of if_instr.
REQ-016 if_ready  in  1  decode accepts when if_valid and if_ready are both high.

Function
REQ-017 Fetch PC (fpc) SHALL advance by 4 on each imem_gnt. imem_addr=fpc. 32-bit arithmetic, wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-018 FSM states: REQ (imem_req=1), WAIT (one request outstanding, imem_req=0), DISCARD (outstanding response to be dropped).
REQ-019 REQ->WAIT on imem_gnt. WAIT->REQ on imem_rvalid (response written to buffer). DISCARD->REQ on imem_rvalid (response dropped).
REQ-020 At most one outstanding request. In REQ, imem_req SHALL be 0 while the buffer has no free entry, counting the slot reserved for the outstanding response.
REQ-021 The request address and PC SHALL be held stable while imem_req=1 and imem_gnt=0.
REQ-022 Buffer: FIFO of {pc, instr}. Head is driven on if_pc/if_instr. if_valid = not empty. Pop on if_valid&&if_ready. A push and a pop in the same cycle on a full buffer SHALL be legal.
REQ-023 Redirect: missaligned_exception has priority and loads fpc=TRAP_VEC; otherwise branchTaken loads fpc=targetADDR[31:2],2'b00.
REQ-024 On a redirect, the buffer SHALL be flushed that cycle: no pop is reported, and if_valid=0 the next cycle.
REQ-025 On a redirect in WAIT, or in REQ with imem_gnt=1 the same cycle, next state SHALL be DISCARD. Otherwise next state SHALL be REQ.
REQ-026 An imem_rvalid coincident with a redirect SHALL be dropped, and next state SHALL be REQ.
REQ-027 A redirect in DISCARD SHALL only update fpc. If that redirect coincides with imem_rvalid, next state SHALL be REQ.
REQ-028 Minimum latency: redirect at cycle N SHALL give imem_req=1 with the new address at N+1 (no outstanding request). Response at cycle M SHALL give if_valid=1 at M+1.

Reset
REQ-029 While rst_n=0: state=REQ, fpc=RESET_PC, buffer empty, imem_req=0, if_valid=0, if_pc=0, if_instr=0.
REQ-030 imem_req SHALL first assert in the first clk edge cycle after rst_n deasserts.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request. A late imem_rvalid after reset, before any grant, SHALL be ignored.

Configuration
REQ-032 Macro FETCH_BUF2_EN defined: the buffer SHALL be a 2-entry FIFO, allowing back-to-back fetch while decode stalls one cycle.
REQ-033 FETCH_BUF2_EN undefined: the buffer SHALL be 1 entry. A new request SHALL issue only when that entry is empty or popping, and no response is outstanding.
REQ-034 Redirect, discard and reset behaviour SHALL be identical in both builds.

Verification
REQ-035 Reset release, RESET_PC=0, gnt same cycle, rvalid next cycle with 32'h00000013, if_ready=1 -> if_pc=0, then imem_addr=4.
REQ-036 Branch at WAIT with targetADDR=32'h100, stale rvalid later -> stale word never reaches if_valid. Next fetch address is 32'h100 after the drop.
REQ-037 missaligned_exception and branchTaken (target 32'h200) in the same cycle -> imem_addr=TRAP_VEC (32'h10).
REQ-038 if_ready=0 for 5 cycles with continuous gnt/rvalid -> FETCH_BUF2_EN: exactly 2 words buffered. Undefined: 1 word buffered. No data lost or duplicated after release.
REQ-039 fpc=32'hFFFF_FFFC fetch granted -> next imem_addr=32'h0000_0000.
REQ-040 rst_n low while WAIT, rvalid the cycle after release -> if_valid stays 0, and imem_addr=RESET_PC.
